// File: rtl/serdes_rx_pkg.sv
// serdes_rx_pkg
// Shared definitions for the receive-side symbol path.
//   SYMBOL_WIDTH         : width of one 8b/10b symbol.
//   COMMA_POS/COMMA_NEG  : 7-bit comma prefixes, bits [9:3] of a symbol with bit 9 = "a".
//   K28_5_NEG/K28_5_POS  : the full K28.5 code groups for the two running disparities.
//   aligner_state_t      : sync state machine states used by symbol_aligner.
package serdes_rx_pkg;

  localparam int SYMBOL_WIDTH = 10;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  localparam logic [9:0] K28_5_NEG = 10'h0FA;
  localparam logic [9:0] K28_5_POS = 10'h305;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } aligner_state_t;

endpackage

// File: rtl/symbol_aligner_comma_search.sv
// comma_search
// Purely combinational comma finder over a 20-bit sliding window.
// Candidate k is window[19-k -: 10] (k = 0..9, bit 19 is the earliest bit).
// Ports:
//   window    in  20  {previous word, current word}
//   hit       out 10  hit[k] = candidate k holds a comma
//   first_hit out 4   lowest k with a hit (0 when there is none)
// Configuration macro: SYMBOL_ALIGNER_FULL_COMMA_EN
//   defined   : only the complete K28.5 code group (either disparity) counts
//   undefined : the 7-bit comma prefix (either disparity) counts
module comma_search
  import serdes_rx_pkg::*;
(
  input  logic [2*SYMBOL_WIDTH-1:0] window,
  output logic [SYMBOL_WIDTH-1:0]   hit,
  output logic [3:0]                first_hit
);

  for (genvar gi = 0; gi < SYMBOL_WIDTH; gi++) begin : g_match
`ifdef SYMBOL_ALIGNER_FULL_COMMA_EN
    logic [SYMBOL_WIDTH-1:0] cand;
    assign cand    = window[2*SYMBOL_WIDTH-1-gi -: SYMBOL_WIDTH];
    assign hit[gi] = (cand == K28_5_NEG) || (cand == K28_5_POS);
`else
    // Only the leading seven bits of a candidate decide a comma.
    logic [6:0] prefix;
    assign prefix  = window[2*SYMBOL_WIDTH-1-gi -: 7];
    assign hit[gi] = (prefix == COMMA_POS) || (prefix == COMMA_NEG);
`endif
  end

  // Scan from the highest offset down so the lowest hitting offset wins.
  always_comb begin
    first_hit = '0;
    for (int k = SYMBOL_WIDTH - 1; k >= 0; k--) begin
      if (hit[k]) first_hit = 4'(k);
    end
  end

endmodule

// File: rtl/symbol_aligner.sv
// symbol_aligner
// Word aligner for the recovered-clock domain. Finds the 8b/10b comma in a
// 20-bit sliding window of raw deserializer words, locks the symbol boundary
// through an UNLOCKED/CHECK/LOCKED sync machine and emits aligned symbols for
// the rx elastic buffer. data_out flows in every state; qualify it with locked.
// Parameters:
//   LOCK_COUNT      aligned commas at one offset needed to declare lock
//   MISALIGN_LIMIT  consecutive misaligned commas that drop lock
// Ports:
//   recovered_clock  in  1   single clock of the block
//   recovered_reset  in  1   asynchronous active-low reset
//   data_in          in  10  raw word, bit 9 earliest ("a")
//   data_out         out 10  aligned symbol, bit 9 = "a"
//   comma_detected   out 1   data_out holds a comma at the current offset
//   locked           out 1   sync machine is in LOCKED
//   realign          out 1   one-cycle pulse, offset register was loaded
//   offset           out 4   current bit offset 0..9
// Configuration macro: SYMBOL_ALIGNER_FULL_COMMA_EN (see comma_search).
module symbol_aligner
  import serdes_rx_pkg::*;
#(
  parameter int LOCK_COUNT     = 3,
  parameter int MISALIGN_LIMIT = 4
) (
  input  logic                    recovered_clock,
  input  logic                    recovered_reset,
  input  logic [SYMBOL_WIDTH-1:0] data_in,
  output logic [SYMBOL_WIDTH-1:0] data_out,
  output logic                    comma_detected,
  output logic                    locked,
  output logic                    realign,
  output logic [3:0]              offset
);

  localparam int ACW = $clog2(LOCK_COUNT + 1);
  localparam int MCW = $clog2(MISALIGN_LIMIT + 1);
  localparam logic [ACW-1:0] ACNT_TOP = ACW'(LOCK_COUNT);
  localparam logic [MCW-1:0] MCNT_TOP = MCW'(MISALIGN_LIMIT);

  aligner_state_t state_reg, state_next;
  logic [SYMBOL_WIDTH-1:0] prev_word_reg;
  logic [3:0]              offset_reg, offset_next;
  logic [ACW-1:0]          aligned_cnt_reg, aligned_cnt_next, aligned_inc;
  logic [MCW-1:0]          misalign_cnt_reg, misalign_cnt_next, misalign_inc;
  logic                    realign_next;

  logic [2*SYMBOL_WIDTH-1:0] window;
  logic [SYMBOL_WIDTH-1:0]   hit;
  logic [3:0]                first_hit;
  logic                      any_hit;
  logic                      aligned_hit;
  logic [3:0]                eff;
  logic [SYMBOL_WIDTH-1:0]   cand [SYMBOL_WIDTH];

  assign window = {prev_word_reg, data_in};

  comma_search u_comma_search (
    .window    (window),
    .hit       (hit),
    .first_hit (first_hit)
  );

  for (genvar gi = 0; gi < SYMBOL_WIDTH; gi++) begin : g_cand
    assign cand[gi] = window[2*SYMBOL_WIDTH-1-gi -: SYMBOL_WIDTH];
  end

  assign any_hit     = |hit;
  assign aligned_hit = hit[offset_reg];

  // Saturating increments; the FSM acts on the saturated value.
  assign aligned_inc  = (aligned_cnt_reg == ACNT_TOP) ? aligned_cnt_reg
                                                      : aligned_cnt_reg + 1'b1;
  assign misalign_inc = (misalign_cnt_reg == MCNT_TOP) ? misalign_cnt_reg
                                                       : misalign_cnt_reg + 1'b1;

  always_comb begin
    state_next        = state_reg;
    offset_next       = offset_reg;
    aligned_cnt_next  = aligned_cnt_reg;
    misalign_cnt_next = misalign_cnt_reg;
    realign_next      = 1'b0;

    case (state_reg)
      UNLOCKED: begin
        if (any_hit) begin
          offset_next      = first_hit;
          realign_next     = 1'b1;
          aligned_cnt_next = ACW'(1);
          state_next       = (LOCK_COUNT <= 1) ? LOCKED : CHECK;
        end
      end

      CHECK: begin
        if (aligned_hit) begin
          aligned_cnt_next = aligned_inc;
          if (aligned_inc == ACNT_TOP) begin
            state_next        = LOCKED;
            misalign_cnt_next = '0;
          end
        end else if (any_hit) begin
          // A comma somewhere else restarts qualification at the new boundary.
          offset_next      = first_hit;
          realign_next     = 1'b1;
          aligned_cnt_next = ACW'(1);
        end
      end

      LOCKED: begin
        // An aligned comma wins over any foreign comma in the same window.
        if (aligned_hit) begin
          misalign_cnt_next = '0;
        end else if (any_hit) begin
          misalign_cnt_next = misalign_inc;
          if (misalign_inc == MCNT_TOP) begin
            state_next        = UNLOCKED;
            aligned_cnt_next  = '0;
            misalign_cnt_next = '0;
          end
        end
      end

      default: begin
        state_next        = UNLOCKED;
        aligned_cnt_next  = '0;
        misalign_cnt_next = '0;
      end
    endcase
  end

  // A realignment steers this cycle's output straight to the new boundary.
  assign eff = realign_next ? first_hit : offset_reg;

  always_ff @(posedge recovered_clock or negedge recovered_reset) begin
    if (!recovered_reset) begin
      state_reg        <= UNLOCKED;
      prev_word_reg    <= '0;
      offset_reg       <= '0;
      aligned_cnt_reg  <= '0;
      misalign_cnt_reg <= '0;
      data_out         <= '0;
      comma_detected   <= 1'b0;
      locked           <= 1'b0;
      realign          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      prev_word_reg    <= data_in;
      offset_reg       <= offset_next;
      aligned_cnt_reg  <= aligned_cnt_next;
      misalign_cnt_reg <= misalign_cnt_next;
      data_out         <= cand[eff];
      comma_detected   <= hit[eff];
      locked           <= (state_next == LOCKED);
      realign          <= realign_next;
    end
  end

  assign offset = offset_reg;

endmodule

// File: tb/tb_symbol_aligner.sv
// tb_symbol_aligner
// Self-checking bench for symbol_aligner: a directed table for the first
// lock-up, hand-written sequences for the lock/unlock corner cases and a
// randomized bit stream compared every cycle against a reference model that
// works on the raw bit window with shifts and plain integer counters.
module tb_symbol_aligner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic [9:0] dout;
  logic       cd, lk, rl;
  logic [3:0] off;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  symbol_aligner #(.LOCK_COUNT(3), .MISALIGN_LIMIT(4)) dut (
    .recovered_clock (clk),
    .recovered_reset (rst_n),
    .data_in         (din),
    .data_out        (dout),
    .comma_detected  (cd),
    .locked          (lk),
    .realign         (rl),
    .offset          (off)
  );

  // ---------------- reference model ----------------
  logic [9:0] m_prev;
  int         m_state;   // 0 = unlocked, 1 = checking, 2 = locked
  int         m_off, m_acnt, m_mcnt;
  logic [9:0] e_dout;
  logic       e_cd, e_lk, e_rl;
  int         e_off;
  bit         saw_rl;
  bit         bq[$];

  function automatic bit m_is_comma(input logic [9:0] c);
`ifdef SYMBOL_ALIGNER_FULL_COMMA_EN
    return (c == 10'h0FA) || (c == 10'h305);
`else
    return ((c >> 3) == 10'h01F) || ((c >> 3) == 10'h060);
`endif
  endfunction

  task automatic model_reset();
    m_prev = '0; m_state = 0; m_off = 0; m_acnt = 0; m_mcnt = 0;
    e_dout = '0; e_cd = 0; e_lk = 0; e_rl = 0; e_off = 0;
  endtask

  task automatic model_step(input logic [9:0] w);
    logic [19:0] win;
    bit          h[10];
    int          fh;
    win = {m_prev, w};
    fh  = -1;
    for (int k = 0; k < 10; k++) begin
      h[k] = m_is_comma(10'(win >> (10 - k)));
      if (h[k] && fh < 0) fh = k;
    end
    e_rl = 0;
    if (m_state == 0) begin
      if (fh >= 0) begin
        m_off = fh; e_rl = 1; m_acnt = 1; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (h[m_off]) begin
        m_acnt++;
        if (m_acnt >= 3) begin m_state = 2; m_mcnt = 0; end
      end else if (fh >= 0) begin
        m_off = fh; e_rl = 1; m_acnt = 1;
      end
    end else begin
      if (h[m_off]) m_mcnt = 0;
      else if (fh >= 0) begin
        m_mcnt++;
        if (m_mcnt >= 4) begin m_state = 0; m_acnt = 0; m_mcnt = 0; end
      end
    end
    e_dout = 10'(win >> (10 - m_off));
    e_cd   = h[m_off];
    e_lk   = (m_state == 2);
    e_off  = m_off;
    m_prev = w;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_model(input string tag);
    checks++;
    if (dout !== e_dout || cd !== e_cd || lk !== e_lk || rl !== e_rl || off !== 4'(e_off)) begin
      errors++;
      $display("FAIL %s: got dout=%h cd=%b lock=%b rl=%b off=%0d, want dout=%h cd=%b lock=%b rl=%b off=%0d",
               tag, dout, cd, lk, rl, off, e_dout, e_cd, e_lk, e_rl, e_off);
    end
  endtask

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // One clock: drive a word, advance the model, sample #1 after the edge.
  task automatic apply(input logic [9:0] w);
    din = w;
    if (!rst_n) model_reset();
    else        model_step(w);
    @(posedge clk);
    #1;
    if (rl) saw_rl = 1;
    check_model("model");
    $display("t=%0t din=%h dout=%h cd=%b lock=%b rl=%b off=%0d", $time, w, dout, cd, lk, rl, off);
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
  endtask

  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) bq.push_back(1'(i % 2));
  endtask

  task automatic feed();
    logic [9:0] w;
    while (bq.size() >= 10) begin
      w = '0;
      for (int i = 0; i < 10; i++) w = {w[8:0], bq.pop_front()};
      apply(w);
    end
  endtask

  task automatic pair(input logic [9:0] k);
    push_sym(k);
    push_sym(10'h2AA);
    feed();
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 10'h0 || cd !== 1'b0 || lk !== 1'b0 || rl !== 1'b0 || off !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got dout=%h cd=%b lock=%b rl=%b off=%0d, want all zero",
               dout, cd, lk, rl, off);
    end
    model_reset();
    @(negedge clk);
    apply(10'($urandom));
    apply(10'($urandom));
    rst_n = 1'b1;
    bq.delete();
  endtask

  function automatic logic [9:0] rotw(input logic [9:0] p, input logic [9:0] c, input int r);
    logic [19:0] t;
    t = {p, c};
    return t[r +: 10];
  endfunction

  typedef struct {
    logic [9:0] din;
    logic [9:0] dout;
    logic       cd;
    logic       lock;
    logic [3:0] off;
    logic       rl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [9:0] comma_set[5];
    int         r;

    // K28.5/D21.5 stream rotated by 3 bits; symbol m-1 emerges after word m.
    vecs[0] = '{rotw(10'h2AA, 10'h0FA, 3), 10'h000, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{rotw(10'h0FA, 10'h2AA, 3), 10'h0FA, 1'b1, 1'b0, 4'd3, 1'b1};
    vecs[2] = '{rotw(10'h2AA, 10'h0FA, 3), 10'h2AA, 1'b0, 1'b0, 4'd3, 1'b0};
    vecs[3] = '{rotw(10'h0FA, 10'h2AA, 3), 10'h0FA, 1'b1, 1'b0, 4'd3, 1'b0};
    vecs[4] = '{rotw(10'h2AA, 10'h0FA, 3), 10'h2AA, 1'b0, 1'b0, 4'd3, 1'b0};
    vecs[5] = '{rotw(10'h0FA, 10'h2AA, 3), 10'h0FA, 1'b1, 1'b1, 4'd3, 1'b0};
    vecs[6] = '{rotw(10'h2AA, 10'h0FA, 3), 10'h2AA, 1'b0, 1'b1, 4'd3, 1'b0};
    vecs[7] = '{rotw(10'h0FA, 10'h2AA, 3), 10'h0FA, 1'b1, 1'b1, 4'd3, 1'b0};

    comma_set[0] = 10'h0FA; comma_set[1] = 10'h305; comma_set[2] = 10'h0F9;
    comma_set[3] = 10'h0F8; comma_set[4] = 10'h306;

    model_reset();
    saw_rl = 0;

    // Reset held with random input: every output must stay at zero.
    #2;
    for (int i = 0; i < 4; i++) apply(10'($urandom));
    rst_n = 1'b1;

    // Directed table: first lock at offset 3.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].din);
      checks++;
      if (dout !== vecs[i].dout || cd !== vecs[i].cd || lk !== vecs[i].lock ||
          off !== vecs[i].off || rl !== vecs[i].rl) begin
        errors++;
        $display("FAIL table[%0d]: got dout=%h cd=%b lock=%b off=%0d rl=%b, want dout=%h cd=%b lock=%b off=%0d rl=%b",
                 i, dout, cd, lk, off, rl, vecs[i].dout, vecs[i].cd, vecs[i].lock, vecs[i].off, vecs[i].rl);
      end
    end

    // Continue the same stream: last three bits of the D21.5 are still pending.
    bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
    pair(10'h0FA);
    pair(10'h0FA);
    check_val("locked_hold", int'(lk), 1);

    // Bit slip of 4 moves commas to offset 7: four of them drop lock.
    push_pad(4);
    pair(10'h0FA); pair(10'h0FA); pair(10'h0FA);
    check_val("lock_after_3_misaligned", int'(lk), 1);
    pair(10'h0FA);
    check_val("lock_after_4_misaligned", int'(lk), 0);
    check_val("offset_kept_on_unlock", int'(off), 3);
    saw_rl = 0;
    pair(10'h0FA);
    check_val("realign_to_7", int'(saw_rl), 1);
    check_val("offset_7", int'(off), 7);
    pair(10'h0FA); pair(10'h0FA);
    check_val("relock_at_7", int'(lk), 1);

    // 3 misaligned, 1 aligned, 3 misaligned: lock must survive.
    push_pad(6);
    pair(10'h0FA); pair(10'h0FA); pair(10'h0FA);
    push_pad(4);
    pair(10'h0FA);
    push_pad(6);
    pair(10'h0FA); pair(10'h0FA); pair(10'h0FA);
    check_val("lock_survives_cleared_cnt", int'(lk), 1);
    check_val("offset_frozen_7", int'(off), 7);

    // Mid-lock reset, then CHECK at 3 with two commas, then a comma at 5.
    hard_reset();
    push_pad(3);
    pair(10'h0FA); pair(10'h0FA);
    check_val("check_no_lock", int'(lk), 0);
    check_val("check_offset_3", int'(off), 3);
    saw_rl = 0;
    push_pad(2);
    pair(10'h0FA);
    check_val("check_realign_5", int'(saw_rl), 1);
    check_val("check_offset_5", int'(off), 5);
    pair(10'h0FA);
    check_val("check_not_yet_locked", int'(lk), 0);
    pair(10'h0FA);
    check_val("check_locked_5", int'(lk), 1);

    // K28.1 stream: locks only with the 7-bit comma match.
    hard_reset();
    saw_rl = 0;
    push_pad(3);
    for (int i = 0; i < 6; i++) pair(10'h0F9);
`ifdef SYMBOL_ALIGNER_FULL_COMMA_EN
    check_val("k28_1_no_lock", int'(lk), 0);
    check_val("k28_1_no_realign", int'(saw_rl), 0);
`else
    check_val("k28_1_lock", int'(lk), 1);
    check_val("k28_1_offset", int'(off), 3);
`endif

    // Randomized bit stream with commas, slips and noise.
    hard_reset();
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      push_sym(10'($urandom));
      else if (r <= 5) push_sym(comma_set[$urandom_range(0, 4)]);
      else if (r == 6) push_pad($urandom_range(1, 9));
      else             push_sym(10'h2AA);
      feed();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_aligner.md
Name: symbol_aligner

Overview:
- Recovered-clock-domain word aligner that sits directly upstream of the rx elastic buffer.
- Takes raw, arbitrarily bit-rotated 10-bit words from the deserializer and searches a 20-bit sliding window for the 8b/10b comma.
- Locks the symbol boundary through a sync state machine and emits boundary-aligned 10-bit symbols; these are the elastic buffer's data_in.

Parameters:
- LOCK_COUNT, 3, aligned commas at the same offset needed to declare lock.
- MISALIGN_LIMIT, 4, consecutive misaligned commas (no aligned comma between them) that drop lock.

Ports:
- recovered_clock  input  1  recovered clock; the single clock of the block.
- recovered_reset  input  1  asynchronous, active-low reset.
- data_in  input  10  raw deserializer word, one per clock; bit 9 is the earliest received bit ("a").
- data_out  output  10  aligned symbol, bit 9 = "a".
- comma_detected  output  1  data_out holds a comma at the current offset.
- locked  output  1  sync state machine is in LOCKED.
- realign  output  1  one-cycle pulse: the offset register changed this cycle.
- offset  output  4  current bit offset, 0..9.

Behaviour:
- Window: prev_word register, reset to 0, loaded with data_in every clock. window = {prev_word, data_in}, 20 bits; candidate(k) = window[19-k -: 10], k = 0..9.
- Comma match: candidate bits [9:3] equal 7'b0011111 or 7'b1100000. hit[k] is one per offset. When several offsets hit, the lowest k wins (first_hit).
- Effective offset eff: first_hit when a realignment happens this cycle, otherwise the offset register.
- Latency: data_out, comma_detected, locked, realign and offset are all registered.
  - Cycle n+1: data_out = candidate(eff) of cycle n; comma_detected = hit[eff] of cycle n.
  - From the last bit of a symbol entering data_in to that symbol on data_out: 1 clock.
- FSM states: UNLOCKED, CHECK, LOCKED. Encoding lives in the package.
- UNLOCKED:
  - Any hit: offset <= first_hit, realign = 1, aligned_cnt <= 1, go to CHECK.
  - If LOCK_COUNT == 1, go straight to LOCKED instead.
- CHECK:
  - hit[offset]: aligned_cnt++. On reaching LOCK_COUNT, go to LOCKED.
  - A hit only at other offsets: offset <= first_hit, realign = 1, aligned_cnt <= 1, stay in CHECK.
  - No hit: hold.
- LOCKED:
  - Offset is frozen.
  - hit[offset] clears misalign_cnt.
  - A hit at other offsets without hit[offset] increments misalign_cnt.
  - misalign_cnt reaching MISALIGN_LIMIT: go to UNLOCKED, clear both counters, locked drops on the next edge, offset is kept.
  - hit[offset] and a foreign hit in the same cycle count as aligned.
- Counters saturate. aligned_cnt is clog2(LOCK_COUNT+1) bits wide; misalign_cnt is sized likewise.
- Reset (async assert, sync release):
  - All registers go to 0: state = UNLOCKED, offset = 0, data_out = 0, comma_detected = 0, locked = 0, realign = 0.
  - A reset asserted mid-lock takes effect immediately, with no drain.
- data_out flows continuously in every state. Consumers qualify it with locked.

Optional Feature:
- Macro: SYMBOL_ALIGNER_FULL_COMMA_EN.
- Defined: a hit requires the full 10-bit K28.5, i.e. candidate == 10'b0011111010 or 10'b1100000101. K28.1/K28.7 no longer align.
- Undefined: 7-bit comma match as above.

Decomposition:
- Package serdes_rx_pkg holds:
  - the aligner_state_t enum;
  - COMMA_POS = 7'b0011111 and COMMA_NEG = 7'b1100000;
  - K28_5_NEG = 10'h0FA and K28_5_POS = 10'h305;
  - SYMBOL_WIDTH = 10.
- One sub-module, comma_search. It is purely combinational: window in, hit[9:0] and first_hit out.
- The FSM, counters and output registers stay in symbol_aligner.

Test Plan:
- Reset: hold recovered_reset = 0 with random data_in → data_out = 0, locked = 0, offset = 0, realign = 0.
- Stream K28.5 (10'h0FA), D21.5 (10'h2AA), K28.5, D21.5 … rotated by 3 bits → realign pulses once and offset = 3; locked rises on the 3rd comma; thereafter data_out alternates 0FA/2AA with comma_detected on 0FA.
- While LOCKED at offset 3: inject 4 commas at offset 7 with no aligned comma between → locked drops after the 4th. Next hit at 7 → realign, offset = 7.
- While LOCKED: inject 3 misaligned commas, then 1 aligned, then 3 misaligned → locked stays 1 (counter cleared).
- In CHECK with aligned_cnt = 2 at offset 3: a comma at offset 5 → offset = 5, aligned_cnt = 1; two more at 5 → locked.
- With SYMBOL_ALIGNER_FULL_COMMA_EN: a K28.1 stream (10'h0F9) → never realigns, locked stays 0. The same stream without the macro locks.
